// File: rtl/p_arbiter_rr_pkg.sv
// p_arbiter_rr_pkg
// Shared definitions for the round-robin priority arbiter slice.
//   - arbState_e : two-state grant engine encoding (IDLE / GRANT)
//   - N_MIN/N_MAX: legal range for the channel-count parameter
// Imported by p_arbiter_rr and p_encoder_param.
package p_arbiter_rr_pkg;

    // IDLE waits for any request; GRANT presents a grant until ack or withdrawal.
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } arbState_e;

    localparam int N_MIN = 2;
    localparam int N_MAX = 64;

endpackage

// File: rtl/p_encoder_param.sv
// p_encoder_param
// Parametrised combinational highest-set-bit encoder.
// Ports:
//   vec  in  N      input vector
//   idx  out IDX_W  index of the highest set bit (0 when vec is zero)
//   any  out 1      at least one bit of vec is set
module p_encoder_param
    import p_arbiter_rr_pkg::*;
#(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
)
(
    input  logic [N-1:0]     vec,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Walk upward so that the last set bit seen, i.e. the highest one,
    // is the one left in idx when the loop finishes.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/p_arbiter_rr.sv
// p_arbiter_rr
// Registered N-channel priority arbiter with valid/ack handshake.
// Round-robin by default: ptr names the top-priority channel, the search runs
// downward from ptr and wraps, and after each accepted grant ptr moves to the
// channel just below the winner so the winner drops to lowest priority.
// Build option: define P_ARB_FIXED_PRIO_EN for plain fixed priority (highest
// set index always wins, ptr frozen at N-1).
// Ports:
//   clk        in  1      rising-edge clock
//   reset      in  1      asynchronous active-high reset
//   req        in  N      request vector
//   ack        in  1      consumer accepts the presented grant
//   gnt_valid  out 1      grant is being presented
//   gnt_onehot out N      one-hot grant, zero when idle
//   gnt_idx    out IDX_W  binary grant index, zero when idle
//   ptr        out IDX_W  current top-priority channel
module p_arbiter_rr
    import p_arbiter_rr_pkg::*;
#(
    parameter  int N     = 8,
    localparam int IDX_W = $clog2(N)
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic             ack,
    output logic             gnt_valid,
    output logic [N-1:0]     gnt_onehot,
    output logic [IDX_W-1:0] gnt_idx,
    output logic [IDX_W-1:0] ptr
);

    localparam logic [IDX_W-1:0] TOP_IDX     = IDX_W'(N - 1);
    localparam logic [N-1:0]     ONE_HOT_LSB = N'(1);

    // Refuse to elaborate with a channel count outside the supported range.
    if (N < N_MIN || N > N_MAX) begin : gBadN
        $error("p_arbiter_rr: N must be within 2..64");
    end

    arbState_e        state;
    logic [IDX_W-1:0] ackPtr;
    logic [IDX_W-1:0] arbPtr;
    logic [N-1:0]     maskedReq;
    logic [IDX_W-1:0] maskedIdx;
    logic [IDX_W-1:0] rawIdx;
    logic [IDX_W-1:0] winIdx;
    logic             maskedAny;
    logic             rawAny;
    logic             grantedStillReq;

    // ackPtr is where ptr lands when the current grant is accepted.
`ifdef P_ARB_FIXED_PRIO_EN
    assign ackPtr = TOP_IDX;
`else
    assign ackPtr = (gnt_idx == '0) ? TOP_IDX : gnt_idx - IDX_W'(1);
`endif

    // On an ack cycle the back-to-back grant must already use the updated
    // pointer, so arbitration looks at ackPtr instead of the stored ptr.
    assign arbPtr = (state == S_GRANT && ack) ? ackPtr : ptr;

    // Keep only requests at or below the pointer; if none survive, the
    // search has wrapped and the highest raw request wins instead.
    always_comb begin
        maskedReq = '0;
        for (int i = 0; i < N; i++) begin
            maskedReq[i] = req[i] && (i <= int'(arbPtr));
        end
    end

    p_encoder_param #(.N(N), .IDX_W(IDX_W)) uMaskedEnc (
        .vec (maskedReq),
        .idx (maskedIdx),
        .any (maskedAny)
    );

    p_encoder_param #(.N(N), .IDX_W(IDX_W)) uRawEnc (
        .vec (req),
        .idx (rawIdx),
        .any (rawAny)
    );

    assign winIdx          = maskedAny ? maskedIdx : rawIdx;
    assign grantedStillReq = req[gnt_idx];

    // Grant engine: every output is a register. In GRANT the outputs hold
    // until either ack (advance pointer, possibly grant again at once) or the
    // granted requester withdraws (cancel without touching the pointer).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            gnt_valid  <= 1'b0;
            gnt_onehot <= '0;
            gnt_idx    <= '0;
            ptr        <= TOP_IDX;
        end else begin
            case (state)
                S_IDLE: begin
                    if (rawAny) begin
                        state      <= S_GRANT;
                        gnt_valid  <= 1'b1;
                        gnt_onehot <= ONE_HOT_LSB << winIdx;
                        gnt_idx    <= winIdx;
                    end
                end
                S_GRANT: begin
                    if (ack) begin
                        ptr <= ackPtr;
                        if (rawAny) begin
                            gnt_onehot <= ONE_HOT_LSB << winIdx;
                            gnt_idx    <= winIdx;
                        end else begin
                            state      <= S_IDLE;
                            gnt_valid  <= 1'b0;
                            gnt_onehot <= '0;
                            gnt_idx    <= '0;
                        end
                    end else if (!grantedStillReq) begin
                        state      <= S_IDLE;
                        gnt_valid  <= 1'b0;
                        gnt_onehot <= '0;
                        gnt_idx    <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_p_arbiter_rr.sv
// tb_p_arbiter_rr
// Scoreboard bench for p_arbiter_rr (N=8). The driver issues req/ack on the
// falling edge, steps a behavioural model written as a plain wrap-around
// scan, and queues the expected registered outputs; a monitor pops and
// compares one entry after each rising edge.
// Honours P_ARB_FIXED_PRIO_EN so the same bench covers both builds.
module tb_p_arbiter_rr;

    localparam int N     = 8;
    localparam int IDX_W = 3;

`ifdef P_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    typedef struct {
        bit valid;
        int idx;
        int ptr;
    } expEntry_t;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     req;
    logic             ack;
    logic             gnt_valid;
    logic [N-1:0]     gnt_onehot;
    logic [IDX_W-1:0] gnt_idx;
    logic [IDX_W-1:0] ptr;

    expEntry_t expQ[$];
    int checkCount = 0;
    int failCount  = 0;

    // Reference model state
    bit mValid;
    int mIdx;
    int mPtr;

    p_arbiter_rr #(.N(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .ack        (ack),
        .gnt_valid  (gnt_valid),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .ptr        (ptr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // First requesting channel found scanning down from startPtr with wrap.
    function automatic int arbitrate(input logic [N-1:0] r, input int startPtr);
        for (int k = 0; k < N; k++) begin
            int c;
            c = (startPtr - k + N) % N;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic modelReset();
        mValid = 1'b0;
        mIdx   = 0;
        mPtr   = N - 1;
    endtask

    // One clock of the specified grant behaviour.
    task automatic modelStep(input logic [N-1:0] r, input logic a);
        int w;
        if (!mValid) begin
            w = arbitrate(r, mPtr);
            if (w >= 0) begin
                mValid = 1'b1;
                mIdx   = w;
            end
        end else if (a) begin
            if (!FIXED) mPtr = (mIdx == 0) ? N - 1 : mIdx - 1;
            w = arbitrate(r, mPtr);
            if (w >= 0) begin
                mIdx = w;
            end else begin
                mValid = 1'b0;
                mIdx   = 0;
            end
        end else if (!r[mIdx]) begin
            mValid = 1'b0;
            mIdx   = 0;
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] r, input logic a);
        expEntry_t e;
        @(negedge clk);
        req = r;
        ack = a;
        modelStep(r, a);
        e.valid = mValid;
        e.idx   = mIdx;
        e.ptr   = mPtr;
        expQ.push_back(e);
    endtask

    // Assert reset between clock edges and check it acts without an edge.
    task automatic doReset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        req   = '0;
        ack   = 1'b0;
        #1;
        checkOutput("rst_gnt_valid", gnt_valid, 0);
        checkOutput("rst_gnt_onehot", gnt_onehot, 0);
        checkOutput("rst_gnt_idx", gnt_idx, 0);
        checkOutput("rst_ptr", ptr, N - 1);
        expQ.delete();
        modelReset();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: compare the queued expectation just after each rising edge.
    always @(posedge clk) begin : monitor
        expEntry_t    e;
        logic [N-1:0] expHot;
        #1;
        if (expQ.size() > 0) begin
            e      = expQ.pop_front();
            expHot = e.valid ? (N'(1) << e.idx) : '0;
            checkOutput("gnt_valid", gnt_valid, e.valid);
            checkOutput("gnt_idx", gnt_idx, e.idx);
            checkOutput("gnt_onehot", gnt_onehot, expHot);
            checkOutput("ptr", ptr, e.ptr);
        end
    end

    initial begin
        logic [N-1:0] r;
        reset = 1'b1;
        req   = '0;
        ack   = 1'b0;
        modelReset();
        doReset();

        // Single request held without ack, then accepted
        applyStimulus(8'h04, 1'b0);
        repeat (5) applyStimulus(8'h04, 1'b0);
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'h00, 1'b1);

        // Rotation with every channel requesting
        doReset();
        repeat (11) applyStimulus(8'hFF, 1'b1);
        applyStimulus(8'h00, 1'b1);

        // Ladder from reset
        for (int k = 0; k < N; k++) begin
            doReset();
            r = '0;
            for (int b = 0; b <= k; b++) r[b] = 1'b1;
            applyStimulus(r, 1'b0);
            applyStimulus(r, 1'b1);
        end

        // Withdrawal while another channel waits
        doReset();
        applyStimulus(8'h08, 1'b0);
        applyStimulus(8'h02, 1'b0);
        applyStimulus(8'h02, 1'b0);
        applyStimulus(8'h02, 1'b1);

        // Fairness between the two extreme channels
        doReset();
        repeat (8) applyStimulus(8'h81, 1'b1);

        // Reset mid-grant on channel 5 after the pointer has moved
        applyStimulus(8'h20, 1'b0);
        doReset();

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            r = N'($urandom);
            case ($urandom_range(0, 3))
                0: r = '0;
                1: r = r & N'($urandom);
                default: ;
            endcase
            applyStimulus(r, 1'($urandom_range(0, 1)));
            if (n == 200) doReset();
        end

        @(posedge clk);
        #3;
        checkOutput("queue_drained", expQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
